// File: rtl/uart_rx_core.sv
// uart_rx_core -- UART receiver with programmable bit period.
//
// Deserializes the asynchronous rx_i line. Supports 5 to 8 data bits,
// optional even/odd parity and a checked stop bit. Each received byte is
// presented on a one-entry valid/ready holding register, together with its
// parity and framing error flags.
//
// Ports:
//   clk_i           sole clock
//   rst_i           synchronous, active-high reset
//   rx_i            asynchronous serial line, idle high
//   clk_div_i       clk_i cycles per bit (values below MIN_DIV use MIN_DIV)
//   data_bits_i     data length: 0->5, 1->6, 2->7, 3->8 bits
//   parity_en_i     1 = parity bit present
//   parity_type_i   0 = even, 1 = odd
//   rx_data_o       received data, LSB = first bit, unused MSBs = 0
//   rx_parity_err_o parity mismatch for the held frame
//   rx_frame_err_o  stop bit sampled low for the held frame
//   rx_valid_o      holding register full
//   rx_ready_i      consumer accepts when rx_valid_o & rx_ready_i
//   overrun_o       one-cycle pulse: finished frame dropped, register full
//   busy_o          receiver is not idle
module uart_rx_core #(
  parameter int unsigned MIN_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [15:0] clk_div_i,
  input  logic [1:0]  data_bits_i,
  input  logic        parity_en_i,
  input  logic        parity_type_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_parity_err_o,
  output logic        rx_frame_err_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Line synchronizer and falling-edge detector (all reset to idle high)
  // ---------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic fall;

  // NOTE: every flop below uses <= so all of them sample the values from
  // before the clock edge; blocking assignments here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall = rx_prev_q & ~rx_sync_q;

  // ---------------------------------------------------------------------
  // Frame configuration and bit timing
  // ---------------------------------------------------------------------
  logic [15:0] div_in;      // clamped divider from the live input
  logic [15:0] div_q;       // divider latched for the current frame
  logic [1:0]  data_bits_q;
  logic        par_en_q;
  logic        par_type_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        par_err_q;
  logic        tick;
  logic        last_bit;
  logic        start_det;
  logic        deliver;

  assign div_in   = (clk_div_i < MIN_DIV_W) ? MIN_DIV_W : clk_div_i;
  assign tick     = (cnt_q == 16'd0);
  assign last_bit = (bit_idx_q == (3'd4 + {1'b0, data_bits_q}));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d, start_det and deliver get a default before the case, so
  // no path through this block leaves them unassigned and no latch appears.
  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    deliver   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          start_det = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (tick) state_d = rx_sync_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && last_bit) state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          deliver = 1'b1;
          // A low stop bit may be a break; wait for the line to go high
          // before looking for another start edge.
          state_d = rx_sync_q ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q       <= 16'd0;
      data_bits_q <= 2'd0;
      par_en_q    <= 1'b0;
      par_type_q  <= 1'b0;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'd0;
      par_err_q   <= 1'b0;
    end else begin
      if (start_det) begin
        div_q       <= div_in;
        data_bits_q <= data_bits_i;
        par_en_q    <= parity_en_i;
        par_type_q  <= parity_type_i;
        // First expiry lands in the middle of the start bit.
        cnt_q       <= (div_in >> 1) - 16'd1;
        bit_idx_q   <= 3'd0;
        shreg_q     <= 8'd0;
        par_err_q   <= 1'b0;
      end else if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
        cnt_q <= tick ? (div_q - 16'd1) : (cnt_q - 16'd1);
      end

      // Bits land at their own index, so unused MSBs stay at zero.
      if (state_q == S_DATA && tick) begin
        shreg_q[bit_idx_q] <= rx_sync_q;
        bit_idx_q          <= bit_idx_q + 3'd1;
      end

      // Unused MSBs are zero, so XOR over all 8 bits is the data parity.
      if (state_q == S_PARITY && tick) begin
        par_err_q <= rx_sync_q ^ (^shreg_q) ^ par_type_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // One-entry holding register towards the consumer
  // ---------------------------------------------------------------------
  logic accept;

  assign accept = rx_valid_o & rx_ready_i;

  // NOTE: the data and flag registers are reset too, not only the valid
  // bit, because their reset value is visible on the outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o       <= 8'd0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_valid_o      <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (deliver) begin
        // A pop in the same cycle frees the entry for the new frame.
        if (!rx_valid_o || accept) begin
          rx_data_o       <= shreg_q;
          rx_parity_err_o <= par_err_q;
          rx_frame_err_o  <= ~rx_sync_q;
          rx_valid_o      <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (accept) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core -- self-checking bench for uart_rx_core.
//
// Frames are driven on rx_i bit by bit; expected data, error flags and
// result latency come from a frame-level model of the serial format.
// Outputs are sampled on the falling clock edge, inputs change 1 ns after
// the rising edge.
module tb_uart_rx_core;

  localparam int MIN_DIV = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } frame_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_i;
  logic [15:0] clk_div_i;
  logic [1:0]  data_bits_i;
  logic        parity_en_i;
  logic        parity_type_i;
  logic [7:0]  rx_data_o;
  logic        rx_parity_err_o;
  logic        rx_frame_err_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        overrun_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_core #(.MIN_DIV(MIN_DIV)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rx_i           (rx_i),
    .clk_div_i      (clk_div_i),
    .data_bits_i    (data_bits_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .rx_data_o      (rx_data_o),
    .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o (rx_frame_err_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .overrun_o      (overrun_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------
  // Output monitor
  // ---------------------------------------------------------------------
  int     cyc = 0;
  logic   busy_prev = 1'b0;
  logic   valid_prev = 1'b0;
  int     busy_rise_cyc = 0;
  int     ovr_cnt = 0;
  int     ovr_lat = -1;
  frame_t got_q[$];
  int     lat_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // busy_o rises one cycle after start detection, so (valid rise - busy
  // rise) is the stop-sample offset from detection.
  always @(negedge clk_i) begin
    busy_prev  <= busy_o;
    valid_prev <= rx_valid_o;
    if (busy_o && !busy_prev) busy_rise_cyc <= cyc;
    if (rx_valid_o && !valid_prev) lat_q.push_back(cyc - busy_rise_cyc);
    if (rx_valid_o && rx_ready_i)
      got_q.push_back(frame_t'({rx_data_o, rx_parity_err_o, rx_frame_err_o}));
    if (overrun_o) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_lat <= cyc - busy_rise_cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------
  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_got(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      wait_cyc(1);
    end
    if (got_q.size() > 0) ok = 1'b1;
  endtask

  // Drives one frame on the line; optionally scrambles the configuration
  // inputs right after the start bit.
  task automatic send_frame(input logic [7:0] d, input int n, input bit pen,
                            input bit pbit, input bit stop_bit, input int bitlen,
                            input bit scramble);
    rx_i = 1'b0;
    wait_cyc(bitlen);
    if (scramble) begin
      clk_div_i     = 16'($urandom_range(100, 300));
      data_bits_i   = 2'($urandom);
      parity_en_i   = ~parity_en_i;
      parity_type_i = ~parity_type_i;
    end
    for (int k = 0; k < n; k++) begin
      rx_i = d[k];
      wait_cyc(bitlen);
    end
    if (pen) begin
      rx_i = pbit;
      wait_cyc(bitlen);
    end
    rx_i = stop_bit;
    wait_cyc(bitlen);
    rx_i = 1'b1;
  endtask

  // Sends one frame and compares the delivered result with the model.
  task automatic run_frame(input string tag, input logic [15:0] div_in,
                           input logic [1:0] db, input bit pen, input bit pty,
                           input logic [7:0] d, input bit bad_par,
                           input bit bad_stop, input bit scramble);
    int         n;
    int         bitlen;
    int         exp_lat;
    logic [7:0] m;
    bit         pbit;
    bit         stop_bit;
    bit         exp_pe;
    bit         ok;
    frame_t     f;
    int         lat;

    n      = 5 + int'(db);
    bitlen = (int'(div_in) < MIN_DIV) ? MIN_DIV : int'(div_in);
    m      = d;
    for (int k = n; k < 8; k++) m[k] = 1'b0;
    pbit     = (^m) ^ pty ^ bad_par;
    stop_bit = !bad_stop;
    exp_pe   = pen && (pbit != ((^m) ^ pty));
    exp_lat  = bitlen / 2 + (n + (pen ? 1 : 0) + 1) * bitlen;

    clk_div_i     = div_in;
    data_bits_i   = db;
    parity_en_i   = pen;
    parity_type_i = pty;
    send_frame(d, n, pen, pbit, stop_bit, bitlen, scramble);

    wait_got(4 * bitlen + 16, ok);
    if (!ok) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      f = got_q.pop_front();
      check({tag, "_data"}, f.data, m);
      check({tag, "_perr"}, f.pe, exp_pe);
      check({tag, "_ferr"}, f.fe, !stop_bit);
      if (lat_q.size() > 0) begin
        lat = lat_q.pop_front();
        check({tag, "_lat"}, lat, exp_lat);
      end else begin
        check({tag, "_lat_missing"}, 0, 1);
      end
    end
    wait_cyc(bad_stop ? bitlen : 2);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    frame_t f;
    bit     ok;
    int     ovr_base;

    rst_i         = 1'b1;
    rx_i          = 1'b1;
    rx_ready_i    = 1'b1;
    clk_div_i     = 16'd16;
    data_bits_i   = 2'd3;
    parity_en_i   = 1'b0;
    parity_type_i = 1'b0;
    wait_cyc(3);
    check("rst_data",  rx_data_o, 0);
    check("rst_perr",  rx_parity_err_o, 0);
    check("rst_ferr",  rx_frame_err_o, 0);
    check("rst_valid", rx_valid_o, 0);
    check("rst_ovr",   overrun_o, 0);
    check("rst_busy",  busy_o, 0);
    rst_i = 1'b0;
    wait_cyc(3);
    got_q.delete();
    lat_q.delete();

    // 8N1 at 16 cycles per bit: stop sample at D + 8 + 9*16.
    run_frame("a5", 16'd16, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);

    // 8E1: 0x3C has four ones, even parity bit is 0.
    run_frame("p3c_bad", 16'd16, 2'd3, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    run_frame("p3c_ok",  16'd16, 2'd3, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    // 7O1 with the configuration scrambled mid-frame.
    run_frame("s55", 16'd16, 2'd2, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    // 7 data bits with bit 7 set in the byte driven: MSB must read 0.
    run_frame("s_d5", 16'd16, 2'd2, 1'b0, 1'b0, 8'hD5, 1'b0, 1'b0, 1'b0);

    // Divider below MIN_DIV behaves as MIN_DIV.
    run_frame("mindiv", 16'd1, 2'd3, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0);

    // Overrun: consumer stalled across two frames.
    clk_div_i     = 16'd16;
    data_bits_i   = 2'd3;
    parity_en_i   = 1'b0;
    parity_type_i = 1'b0;
    rx_ready_i    = 1'b0;
    got_q.delete();
    lat_q.delete();
    ovr_base = ovr_cnt;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    wait_cyc(4);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    wait_cyc(20);
    check("ovr_valid", rx_valid_o, 1);
    check("ovr_held",  rx_data_o, 8'h11);
    check("ovr_pulses", ovr_cnt - ovr_base, 1);
    check("ovr_time",  ovr_lat, 8 + 9 * 16);
    check("ovr_nopop", got_q.size(), 0);
    rx_ready_i = 1'b1;
    wait_cyc(2);
    check("pop_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      f = got_q.pop_front();
      check("pop_data", f.data, 8'h11);
    end
    check("pop_valid", rx_valid_o, 0);

    // Short low glitch on an idle line: no frame, receiver returns to idle.
    got_q.delete();
    lat_q.delete();
    rx_i = 1'b0;
    wait_cyc(3);
    rx_i = 1'b1;
    wait_cyc(48);
    check("glitch_nofrm", got_q.size(), 0);
    check("glitch_busy",  busy_o, 0);

    // Break: 20 bit times low gives one all-zero frame with a framing error.
    rx_i = 1'b0;
    wait_cyc(20 * 16);
    check("brk_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      f = got_q.pop_front();
      check("brk_data", f.data, 8'h00);
      check("brk_perr", f.pe, 0);
      check("brk_ferr", f.fe, 1);
    end
    check("brk_busy", busy_o, 1);
    if (lat_q.size() > 0) check("brk_lat", lat_q.pop_front(), 8 + 9 * 16);
    else check("brk_lat_missing", 0, 1);
    rx_i = 1'b1;
    wait_cyc(6);
    check("brk_idle",  busy_o, 0);
    check("brk_extra", got_q.size(), 0);

    // Reset in the middle of data bit 4 while a frame is held.
    rx_ready_i = 1'b0;
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    wait_cyc(10);
    check("rsm_held", rx_valid_o, 1);
    rx_i = 1'b0;
    wait_cyc(16);
    rx_i = 1'b1;
    wait_cyc(4 * 16);
    rx_i = 1'b0;
    wait_cyc(8);
    check("rsm_busy", busy_o, 1);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    wait_cyc(1);
    check("rsm_data",  rx_data_o, 0);
    check("rsm_perr",  rx_parity_err_o, 0);
    check("rsm_ferr",  rx_frame_err_o, 0);
    check("rsm_valid", rx_valid_o, 0);
    check("rsm_ovr",   overrun_o, 0);
    check("rsm_bsy0",  busy_o, 0);
    rst_i = 1'b0;
    rx_ready_i = 1'b1;
    wait_cyc(5);
    got_q.delete();
    lat_q.delete();
    run_frame("after_rst", 16'd16, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Randomized frames against the model.
    for (int i = 0; i < 40; i++) begin
      run_frame($sformatf("rnd%0d", i),
                16'($urandom_range(0, 20)),
                2'($urandom),
                1'($urandom),
                1'($urandom),
                8'($urandom),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0),
                1'($urandom));
    end

    wait_got(4, ok);
    check("no_spurious", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
